// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and C/N/Z/V flags.
// Define ALU_SHIFT_EN to build the serial one-bit-per-cycle SHL/SHR path.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [2:0]       Control_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] R_o,
  output logic             C_o,
  output logic             N_o,
  output logic             Z_o,
  output logic             V_o
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH:0] add_s, sub_s;
  logic [WIDTH-1:0] r;
  logic c, v, v_add, v_sub, acc, go_shift;
  assign in_ready_o = !rst_i && (state == IDLE || (state == DONE && out_ready_i));
  assign acc = in_valid_i && in_ready_o;
  assign add_s = {1'b0, A_i} + {1'b0, B_i};
  assign sub_s = {1'b0, A_i} + {1'b0, ~B_i} + (WIDTH+1)'(1);
  assign v_add = (A_i[WIDTH-1] == B_i[WIDTH-1]) && (add_s[WIDTH-1] != A_i[WIDTH-1]);
  assign v_sub = (A_i[WIDTH-1] != B_i[WIDTH-1]) && (sub_s[WIDTH-1] != A_i[WIDTH-1]);
  always_comb begin
    r = A_i;
    c = 1'b0;
    v = 1'b0;
    case (Control_i)
      3'b000: begin r = add_s[WIDTH-1:0]; c = add_s[WIDTH]; v = v_add; end
      3'b001: begin r = sub_s[WIDTH-1:0]; c = sub_s[WIDTH]; v = v_sub; end
      3'b010: r = A_i | B_i;
      3'b011: r = A_i & B_i;
      3'b100: r = A_i ^ B_i;
      3'b101: begin r = WIDTH'(sub_s[WIDTH-1] ^ v_sub); c = sub_s[WIDTH]; v = v_sub; end
      default: ;
    endcase
  end
`ifdef ALU_SHIFT_EN
  localparam int CW = SW + 1;
  logic [CW-1:0] k, cnt;
  logic [WIDTH-1:0] w, w_n;
  logic dir, c_n;
  // amounts past the datapath width saturate to WIDTH, which clears the word
  assign k = ({1'b0, B_i[SW-1:0]} >= CW'(WIDTH)) ? CW'(WIDTH) : {1'b0, B_i[SW-1:0]};
  assign w_n = dir ? w >> 1 : w << 1;
  assign c_n = dir ? w[0] : w[WIDTH-1];
  assign go_shift = Control_i[2:1] == 2'b11 && k != '0;
`else
  assign go_shift = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      out_valid_o <= 1'b0;
      R_o <= '0;
      C_o <= 1'b0;
      N_o <= 1'b0;
      Z_o <= 1'b0;
      V_o <= 1'b0;
    end else if (acc && go_shift) begin
      state <= SHIFT;
      out_valid_o <= 1'b0;
`ifdef ALU_SHIFT_EN
      w <= A_i;
      cnt <= k;
      dir <= Control_i[0];
`endif
    end else if (acc) begin
      state <= DONE;
      out_valid_o <= 1'b1;
      R_o <= r;
      C_o <= c;
      N_o <= r[WIDTH-1];
      Z_o <= r == '0;
      V_o <= v;
    end else if (state == DONE && out_ready_i) begin
      state <= IDLE;
      out_valid_o <= 1'b0;
    end
`ifdef ALU_SHIFT_EN
    else if (state == SHIFT) begin
      w <= w_n;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= DONE;
        out_valid_o <= 1'b1;
        R_o <= w_n;
        C_o <= c_n;
        N_o <= w_n[WIDTH-1];
        Z_o <= w_n == '0;
        V_o <= 1'b0;
      end
    end
`endif
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 4;
`ifdef ALU_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] ctl = '0;
  logic in_ready, out_valid, cf, nf, zf, vf;
  logic [W-1:0] r;
  int total = 0, bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .A_i(a), .B_i(b), .Control_i(ctl), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .R_o(r), .C_o(cf), .N_o(nf), .Z_o(zf), .V_o(vf)
  );

  always #5 clk = ~clk;

  // expected {R, C, N, Z, V} from the opcode rules using plain integer arithmetic
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int ua, ub, sa, sb, s, k, rr, cc, vv;
    ua = int'(x);
    ub = int'(y);
    sa = ua >= 2**(W-1) ? ua - 2**W : ua;
    sb = ub >= 2**(W-1) ? ub - 2**W : ub;
    k = ub % W;
    rr = ua; cc = 0; vv = 0;
    case (op)
      3'd0: begin
        s = ua + ub; rr = s % 2**W; cc = s / 2**W;
        vv = (sa + sb > 2**(W-1) - 1 || sa + sb < -(2**(W-1))) ? 1 : 0;
      end
      3'd1, 3'd5: begin
        s = ua + (2**W - 1 - ub) + 1; cc = s / 2**W;
        vv = (sa - sb > 2**(W-1) - 1 || sa - sb < -(2**(W-1))) ? 1 : 0;
        rr = op == 3'd1 ? s % 2**W : (sa < sb ? 1 : 0);
      end
      3'd2: rr = ua | ub;
      3'd3: rr = ua & ub;
      3'd4: rr = ua ^ ub;
      3'd6: if (SH && k > 0) begin rr = (ua << k) % 2**W; cc = (ua >> (W - k)) & 1; end
      default: if (SH && k > 0) begin rr = ua >> k; cc = (ua >> (k - 1)) & 1; end
    endcase
    return {rr[W-1:0], cc[0], rr >= 2**(W-1), rr == 0, vv[0]};
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [W-1:0] y);
    return (SH && op[2:1] == 2'b11 && int'(y) % W != 0) ? 1 + int'(y) % W : 1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    logic [W+3:0] e;
    int cyc, l;
    e = model(op, x, y);
    ctl = op; a = x; b = y; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin step(); cyc++; end
    step();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); ctl = 3'($urandom);
    cyc = 0; l = 1;
    while (!out_valid && cyc < 50) begin step(); cyc++; l++; end
    total++;
    if ({r, cf, nf, zf, vf} !== e) begin
      bad++; $display("FAIL %s result: got %b expected %b", name, {r, cf, nf, zf, vf}, e);
    end
    total++;
    if (l !== lat(op, y)) begin
      bad++; $display("FAIL %s latency: got %0d expected %0d", name, l, lat(op, y));
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL %s consume: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    total++;
    if ({in_ready, out_valid, r, cf, nf, zf, vf} !== '0) begin
      bad++; $display("FAIL reset_state: got %b expected 0", {in_ready, out_valid, r, cf, nf, zf, vf});
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release: in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors;
    do_op(3'd0, 4'b0111, 4'b1001, "add_wrap");
    do_op(3'd1, 4'b0100, 4'b0101, "sub_borrow");
    do_op(3'd1, 4'b0111, 4'b1000, "sub_ovf");
    do_op(3'd5, 4'b1000, 4'b0001, "slt_neg");
    do_op(3'd6, 4'b0011, 4'b0010, "shl_2");
    do_op(3'd7, 4'b0011, 4'b0001, "shr_1");
    do_op(3'd6, 4'b1011, 4'b0000, "shl_0");
    do_op(3'd7, 4'b1000, 4'b0011, "shr_3");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      do_op(3'($urandom), W'($urandom), W'($urandom), "random");
  endtask

  task automatic test_backpressure;
    logic [W+3:0] e;
    int cyc;
    e = model(3'd1, 4'b0010, 4'b0111);
    out_ready = 1'b0;
    ctl = 3'd1; a = 4'b0010; b = 4'b0111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin step(); cyc++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready, r, cf, nf, zf, vf} !== {2'b10, e}) begin
        bad++; $display("FAIL stall_hold: got %b expected %b", {out_valid, in_ready, r, cf, nf, zf, vf}, {2'b10, e});
      end
      step();
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [W+3:0] e;
    out_ready = 1'b1;
    ctl = 3'($urandom_range(0, 5)); a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
    e = model(ctl, a, b);
    step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({out_valid, in_ready, r, cf, nf, zf, vf} !== {2'b11, e}) begin
        bad++; $display("FAIL b2b_%0d: got %b expected %b", i, {out_valid, in_ready, r, cf, nf, zf, vf}, {2'b11, e});
      end
      if (i < 9) begin
        ctl = 3'($urandom_range(0, 5)); a = W'($urandom); b = W'($urandom);
        e = model(ctl, a, b);
      end else in_valid = 1'b0;
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_abort;
    do_op(3'd2, 4'b0101, 4'b0010, "pre_abort");
`ifdef ALU_SHIFT_EN
    ctl = 3'd6; a = W'($urandom); b = 4'b0011; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, r, cf, nf, zf, vf} !== {2'b10, {(W+4){1'b0}}}) begin
      bad++; $display("FAIL shift_abort: got %b expected %b", {in_ready, out_valid, r, cf, nf, zf, vf}, {2'b10, {(W+4){1'b0}}});
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL shift_abort_quiet: out_valid got %b expected 0", out_valid);
      end
    end
`endif
    out_ready = 1'b0;
    ctl = 3'd0; a = 4'b0001; b = 4'b0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, r} !== {1'b1, 4'b0011}) begin
      bad++; $display("FAIL done_pre_reset: got %b expected %b", {out_valid, r}, {1'b1, 4'b0011});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    out_ready = 1'b1;
    total++;
    if ({in_ready, out_valid, r, cf, nf, zf, vf} !== {2'b10, {(W+4){1'b0}}}) begin
      bad++; $display("FAIL done_abort: got %b expected %b", {in_ready, out_valid, r, cf, nf, zf, vf}, {2'b10, {(W+4){1'b0}}});
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    do_op(3'd0, 4'b0011, 4'b0100, "post_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
